// File: rtl/alu_share_ctrl.sv
// Purpose : round-robin arbiter/sequencer sharing one 8-bit ALU between two requesters.
// Latency : accept at edge N, tagged response valid after edge N+1 (IDLE->EXEC->HOLD).
// Backpres: response held stable in HOLD until rsp_ready; req*_ready stays low outside IDLE.
// Ports   : Clk/Reset (sync, active-high); req0_*/req1_* valid/ready request channels
//           carrying op, a, b, c; alu_A/B/C/OP operand drive and alu_out/alu_isEqual
//           result return; rsp_valid/rsp_ready tagged response with rsp_id/rsp_data/rsp_eq.
module alu_share_ctrl #(
   parameter int W   = 8,
   parameter int Ops = 3
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [Ops-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [W-1:0]   req0_c,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [Ops-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [W-1:0]   req1_c,
   output logic [W-1:0]   alu_A,
   output logic [W-1:0]   alu_B,
   output logic [W-1:0]   alu_C,
   output logic [Ops-1:0] alu_OP,
   input  logic [W-1:0]   alu_out,
   input  logic           alu_isEqual,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_data,
   output logic           rsp_eq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state_q, state_d;
   // Requester that wins the next tie; flips to the loser after every grant.
   logic           prio_q, prio_d;
   logic [Ops-1:0] op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   c_q, c_d;
   logic           id_q, id_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_id_q, rsp_id_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           rsp_eq_q, rsp_eq_d;

   logic           grant0, grant1;

   // Grants are mutually exclusive by construction: on a tie prio_q picks exactly one.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || !prio_q);
      grant1 = req1_valid && (!req0_valid ||  prio_q);
   end

   assign req0_ready = (state_q == IDLE) && grant0;
   assign req1_ready = (state_q == IDLE) && grant1;

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_eq_d    = rsp_eq_q;

      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               op_d    = grant1 ? req1_op : req0_op;
               a_d     = grant1 ? req1_a  : req0_a;
               b_d     = grant1 ? req1_b  : req0_b;
               c_d     = grant1 ? req1_c  : req0_c;
               id_d    = grant1;
               prio_d  = !grant1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // ALU has had a full cycle on the registered operands.
            rsp_data_d  = alu_out;
            rsp_eq_d    = alu_isEqual;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            // rsp_valid is always set in HOLD, so rsp_ready alone completes the handshake.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_eq_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_eq_q    <= rsp_eq_d;
      end
   end

   // ALU inputs come only from the operand register so they move only on an accept edge.
   assign alu_A     = a_q;
   assign alu_B     = b_q;
   assign alu_C     = c_q;
   assign alu_OP    = op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_eq    = rsp_eq_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Purpose : directed bench for alu_share_ctrl with an attached ALU model and a transaction-level reference.
// Latency : reference expects responses two edges after the accepting edge.
// Backpres: exercises rsp_ready low in HOLD and a pending request behind it.
module tb_alu_share_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [7:0] req0_a = '0, req0_b = '0, req0_c = '0;
   logic [7:0] req1_a = '0, req1_b = '0, req1_c = '0;
   logic       rsp_ready = 1'b1;

   logic       req0_ready, req1_ready;
   logic [7:0] alu_A, alu_B, alu_C;
   logic [2:0] alu_OP;
   logic [7:0] alu_out;
   logic       alu_isEqual;
   logic       rsp_valid, rsp_id, rsp_eq;
   logic [7:0] rsp_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.W(8), .Ops(3)) dut (
      .Clk(clk), .Reset(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
      .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C), .alu_OP(alu_OP),
      .alu_out(alu_out), .alu_isEqual(alu_isEqual),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_eq(rsp_eq)
   );

   // ALU behaviour: add, shift right, shift left, parity-insert with equality compare.
   function automatic logic [7:0] alu_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = a;
      case (op)
         3'b000: r = a + b;
         3'b001: r = a >> b;
         3'b010: r = a << b;
         3'b110: if (b < 8'd8) r[b[2:0]] = ^a;
         default: r = a;
      endcase
      return r;
   endfunction

   function automatic logic alu_eqf(input logic [2:0] op, input logic [7:0] a, input logic [7:0] c);
      return (op == 3'b110) && (a == c);
   endfunction

   always_comb begin
      alu_out     = alu_res(alu_OP, alu_A, alu_B);
      alu_isEqual = alu_eqf(alu_OP, alu_A, alu_C);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one operation in flight, response visible one cycle after accept.
   bit         chk_en  = 1'b0;
   bit         m_busy  = 1'b0;
   bit         m_shown = 1'b0;
   int         m_last  = 1;
   logic       m_id    = 1'b0;
   logic [7:0] m_data  = '0;
   logic       m_eq    = 1'b0;

   function automatic int pick(input logic v0, input logic v1, input int last);
      if (v0 && v1) return 1 - last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int w;
      w = pick(req0_valid, req1_valid, m_last);
      if (rst) begin
         m_busy = 1'b0; m_shown = 1'b0; m_last = 1;
      end else if (!m_busy) begin
         if (w >= 0) begin
            m_busy = 1'b1;
            m_last = w;
            m_id   = (w == 1);
            m_data = (w == 1) ? alu_res(req1_op, req1_a, req1_b) : alu_res(req0_op, req0_a, req0_b);
            m_eq   = (w == 1) ? alu_eqf(req1_op, req1_a, req1_c) : alu_eqf(req0_op, req0_a, req0_c);
         end
      end else if (!m_shown) begin
         m_shown = 1'b1;
      end else if (rsp_ready) begin
         m_busy = 1'b0; m_shown = 1'b0;
      end
   end

   always @(negedge clk) begin : cmp
      int w;
      if (chk_en) begin
         w = m_busy ? -1 : pick(req0_valid, req1_valid, m_last);
         check("req0_ready", req0_ready, w == 0);
         check("req1_ready", req1_ready, w == 1);
         check("rsp_valid", rsp_valid, m_shown);
         if (m_shown) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_data", rsp_data, m_data);
            check("rsp_eq", rsp_eq, m_eq);
         end
      end
   end

   task automatic do_op(input int n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      logic hs, ok;
      ok = 1'b0;
      @(posedge clk); #1;
      if (n == 1) begin
         req1_op = op; req1_a = a; req1_b = b; req1_c = c; req1_valid = 1'b1;
      end else begin
         req0_op = op; req0_a = a; req0_b = b; req0_c = c; req0_valid = 1'b1;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         hs = (n == 1) ? req1_ready : req0_ready;
         @(posedge clk); #1;
         if (hs) begin
            ok = 1'b1;
            break;
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("accept", ok, 1);
   endtask

   task automatic expect_rsp(input logic id, input logic [7:0] data, input logic eq, input string name, input int lat);
      logic got;
      int   k;
      got = 1'b0;
      k   = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            k   = i;
            break;
         end
      end
      check({name, "_seen"}, got, 1);
      if (got) begin
         check({name, "_data"}, rsp_data, data);
         check({name, "_id"}, rsp_id, id);
         check({name, "_eq"}, rsp_eq, eq);
         if (lat > 0) check({name, "_lat"}, k, lat);
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic ids [4];
      logic exp_ids [4];
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};

      // Reset values.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_eq", rsp_eq, 0);
      check("rst_alu_A", alu_A, 0);
      check("rst_alu_B", alu_B, 0);
      check("rst_alu_C", alu_C, 0);
      check("rst_alu_OP", alu_OP, 0);
      check("rst_req0_ready", req0_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Single-requester operations with hand-computed results.
      do_op(0, 3'b000, 8'h05, 8'h03, 8'h00); expect_rsp(1'b0, 8'h08, 1'b0, "add", 2);
      do_op(0, 3'b000, 8'hFF, 8'h02, 8'h00); expect_rsp(1'b0, 8'h01, 1'b0, "add_wrap", 2);
      do_op(1, 3'b110, 8'h5A, 8'h03, 8'h5A); expect_rsp(1'b1, 8'h52, 1'b1, "par_eq", 2);
      do_op(1, 3'b110, 8'h5A, 8'h03, 8'h00); expect_rsp(1'b1, 8'h52, 1'b0, "par_ne", 2);
      do_op(0, 3'b001, 8'h80, 8'h03, 8'h00); expect_rsp(1'b0, 8'h10, 1'b0, "shr", 2);
      do_op(0, 3'b010, 8'h81, 8'h01, 8'h00); expect_rsp(1'b0, 8'h02, 1'b0, "shl", 2);
      do_op(0, 3'b001, 8'hFF, 8'h09, 8'h00); expect_rsp(1'b0, 8'h00, 1'b0, "shr_wide", 2);
      do_op(1, 3'b110, 8'h5A, 8'h08, 8'h00); expect_rsp(1'b1, 8'h5A, 1'b0, "par_wide", 2);

      // Contention from reset: grants must alternate starting with requester 0.
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h01; req0_c = 8'h00;
      req1_op = 3'b000; req1_a = 8'h02; req1_b = 8'h02; req1_c = 8'h00;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ids[i] = 1'bx;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
               ids[i] = rsp_id;
               break;
            end
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) check("tie_id", ids[i], exp_ids[i]);

      // Backpressure with a pending requester behind the held response.
      rsp_ready = 1'b0;
      do_op(1, 3'b000, 8'h10, 8'h20, 8'h00);
      expect_rsp(1'b1, 8'h30, 1'b0, "bp", 2);
      @(posedge clk); #1;
      req0_op = 3'b010; req0_a = 8'h03; req0_b = 8'h02; req0_c = 8'h00; req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rdy0", req0_ready, 0);
         check("bp_hold_data", rsp_data, 8'h30);
         check("bp_hold_valid", rsp_valid, 1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_rdy0_at_hs", req0_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_accept_next", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      expect_rsp(1'b0, 8'h0C, 1'b0, "bp_pend", 2);

      // Reset while in EXEC drops the operation; next tie goes to requester 0.
      do_op(0, 3'b000, 8'h11, 8'h22, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      check("exec_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_rsp", rsp_valid, 0);
      end
      @(posedge clk); #1;
      req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h01; req0_c = 8'h00;
      req1_op = 3'b000; req1_a = 8'h02; req1_b = 8'h02; req1_c = 8'h00;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      check("post_rst_rdy0", req0_ready, 1);
      check("post_rst_rdy1", req1_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      expect_rsp(1'b0, 8'h02, 1'b0, "post_rst", 2);

      repeat (3) @(posedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
